mat_row_streamer: RTL and testbench
===================================

# mat_row_streamer

AXI-stream transmitter that holds an N×N matrix of DW-bit elements and streams it row-major to a matrix-vector multiplier's slave stream port. Asserts tlast on the final element of each row and a separate frame marker on the final element of the matrix. Sits upstream of the multiplier. The matrix is loaded through a simple write port; a start pulse launches one full-frame transfer.

## Interface
- N, default 2: matrix dimension; rows and columns; N ≥ 2.
- DW, default 8: element width in bits.
- IW (localparam) = max(1, $clog2(N)): row/column index width.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset; one clock, synchronous and active-high.
- wr_en  in  1  matrix element write strobe.
- wr_row  in  IW  row index of the write.
- wr_col  in  IW  column index of the write.
- wr_data  in  DW  element value.
- start  in  1  one-cycle request to stream the whole matrix.
- busy  out  1  high from the cycle after an accepted start until the frame completes.
- done  out  1  one-cycle pulse after the last beat is accepted.
- m_axis_tdata  out  DW  current element.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last element of a row (column N-1).
- m_axis_tuser  out  1  last element of the frame (row N-1, column N-1).
- m_axis_tready  in  1  downstream ready.

## Operation
- Storage: N*N registers of DW bits, indexed [row][col]. Reset clears all elements to 0.
- Write port:
  - wr_en is honoured only when busy=0 and start=0.
  - Writes in any other cycle are dropped.
  - Indices ≥ N are dropped.
- FSM states: IDLE, STREAM.
  - IDLE → STREAM: start=1 while in IDLE. Loads beat (0,0) into the output register and sets tvalid=1.
  - start while in STREAM is ignored.
  - STREAM → IDLE: on the handshake (tvalid && tready) of beat (N-1,N-1).
- Beat sequencing:
  - On each handshake the column counter increments.
  - At column N-1 the column counter wraps to 0 and the row counter increments.
  - The next element is loaded into the output register in the same cycle as the handshake.
- AXI rules:
  - tdata, tlast and tuser are stable while tvalid=1 && tready=0.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- Flag rules:
  - tlast = (col == N-1).
  - tuser = (row == N-1 && col == N-1).
  - Both flags are 0 whenever tvalid=0.
- Reset values:
  - All outputs 0: busy, done, tvalid, tlast, tuser, tdata.
  - Counters 0; FSM in IDLE.
- Reset mid-frame: the stream is aborted immediately. tvalid drops the next cycle with no done pulse. Matrix contents are cleared.

## Timing
- start at cycle t (in IDLE) → tvalid=1 and busy=1 at t+1 with tdata=M[0][0].
- With tready held high: one beat per cycle; beat k is presented at t+1+k, for k = 0..N*N-1.
- Final beat handshake at cycle h:
  - At h+1: tvalid=0, busy=0, done=1 (one cycle only).
  - A new start is accepted from h+1 onward; the next first beat appears at h+2.
- tready low stalls the stream indefinitely with all outputs held. There is no bubble after tready returns high.
- A write is visible to the next start issued at least one cycle later.

## Test plan
- Load and stream: N=2, DW=8. Write M = {{1,2},{3,4}}, then start, tready=1.
  - Beats 1,2,3,4 on four consecutive cycles.
  - tlast = 0,1,0,1.
  - tuser = 0,0,0,1.
  - done pulses one cycle after beat 4; busy spans exactly 4 cycles.
- Backpressure: same matrix, tready toggled 1,0,0,1,0,1,1.
  - Sequence 1,2,3,4 delivered with no loss or duplication.
  - tdata, tlast and tuser are stable during stalls.
- Write/start interactions:
  - wr_en to (0,0) with value 9 in the same cycle as start → first beat is the prior value 1.
  - wr_en while busy → dropped.
  - A post-frame write of 9 then a new start → first beat is 9.
- Start while busy: a second start mid-frame → exactly 4 beats and a single done pulse.
- Reset mid-frame: areset after beat 2 is accepted.
  - Next cycle tvalid=0 and busy=0; no done pulse.
  - All elements read back 0 on the next start.
- Back-to-back frames: start issued in the done cycle.
  - The second frame's first beat appears 1 cycle later.
  - 8 beats total with tuser on beats 4 and 8.

Source files
------------

// File: rtl/mat_row_streamer.sv
// mat_row_streamer: holds an N x N matrix and streams it row-major
// over AXI-stream, tlast per row and tuser on the final element.
module mat_row_streamer #(
    parameter int N  = 2,
    parameter int DW = 8,
    localparam int IW = (N > 2) ? $clog2(N) : 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    output logic          m_axis_tuser,
    input  logic          m_axis_tready
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW:0]   NDIM = (IW + 1)'(N);

    logic [DW-1:0] mem [N][N];
    logic [0:0]    state;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [IW-1:0] nrow;
    logic [IW-1:0] ncol;
    logic          hs;
    logic          last_beat;
    logic          wr_ok;

    // Handshake, next beat position and write qualification.
    always_comb begin
        hs        = m_axis_tvalid && m_axis_tready;
        last_beat = (row == LAST) && (col == LAST);
        ncol      = (col == LAST) ? '0 : col + 1'b1;
        nrow      = (col == LAST) ? row + 1'b1 : row;
        wr_ok     = wr_en && !busy && !start
                    && ({1'b0, wr_row} < NDIM)
                    && ({1'b0, wr_col} < NDIM);
    end

    // Matrix storage; writes only land while idle and not starting.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Frame FSM and registered AXI-stream output stage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            row           <= '0;
            col           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_STREAM;
                        busy          <= 1'b1;
                        row           <= '0;
                        col           <= '0;
                        m_axis_tdata  <= mem[0][0];
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        if (last_beat) begin
                            state         <= S_IDLE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            row           <= '0;
                            col           <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                        end else begin
                            row          <= nrow;
                            col          <= ncol;
                            m_axis_tdata <= mem[nrow][ncol];
                            m_axis_tlast <= (ncol == LAST);
                            m_axis_tuser <= (nrow == LAST)
                                            && (ncol == LAST);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_row_streamer.sv
// tb_mat_row_streamer: scoreboard bench for mat_row_streamer
// (N=2, DW=8): load, backpressure, write/start races, reset, b2b.
module tb_mat_row_streamer;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int IW = 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          wr_en;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tready;

    mat_row_streamer #(.N(N), .DW(DW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_col        (wr_col),
        .wr_data       (wr_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW+1:0] sbq [$];
    logic [DW-1:0] model [N][N];

    int cyc         = 0;
    int beat_cnt    = 0;
    int done_cnt    = 0;
    int busy_cnt    = 0;
    int tuser_cnt   = 0;
    int last_hs_cyc = 0;
    int done_cyc    = 0;

    always @(posedge aclk) cyc++;

    // Output monitor: compares every presented beat to the queue head.
    always @(negedge aclk) begin
        if (areset) begin
            sbq.delete();
        end else begin
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_axis_tvalid) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", sbq.size(), 1);
                end else begin
                    check("beat", {m_axis_tdata, m_axis_tlast,
                                   m_axis_tuser}, sbq[0]);
                    if (m_axis_tready) begin
                        void'(sbq.pop_front());
                        beat_cnt++;
                        tuser_cnt += int'(m_axis_tuser);
                        last_hs_cyc = cyc;
                    end
                end
            end else begin
                check("idle_flags", {m_axis_tlast, m_axis_tuser}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(int r, int c, int v, bit ok);
        wr_en   = 1'b1;
        wr_row  = IW'(r);
        wr_col  = IW'(c);
        wr_data = DW'(v);
        tick();
        wr_en = 1'b0;
        if (ok) model[r][c] = DW'(v);
    endtask

    task automatic push_frame();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sbq.push_back({model[r][c], (c == N - 1),
                               (r == N - 1) && (c == N - 1)});
            end
        end
    endtask

    task automatic do_start();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(string tag);
        for (int i = 0; i < 60 && !done; i++) tick();
        check(tag, done, 1);
    endtask

    task automatic load_1234();
        wr(0, 0, 1, 1);
        wr(0, 1, 2, 1);
        wr(1, 0, 3, 1);
        wr(1, 1, 4, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int b_busy;
    int b_done;
    int b_beat;
    int b_tuser;
    int t_first;
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        areset        = 1'b1;
        wr_en         = 1'b0;
        wr_row        = '0;
        wr_col        = '0;
        wr_data       = '0;
        start         = 1'b0;
        m_axis_tready = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) model[r][c] = '0;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        areset = 1'b0;
        tick();

        // Load and stream
        load_1234();
        m_axis_tready = 1'b1;
        b_busy = busy_cnt;
        b_done = done_cnt;
        b_beat = beat_cnt;
        do_start();
        check("t1_valid", m_axis_tvalid, 1);
        check("t1_busy", busy, 1);
        check("t1_first", m_axis_tdata, 1);
        t_first = cyc;
        wait_done("t1_done");
        check("t1_done_busy", busy, 0);
        check("t1_done_valid", m_axis_tvalid, 0);
        tick();
        check("t1_done_once", done, 0);
        check("t1_busy_cnt", busy_cnt - b_busy, 4);
        check("t1_done_cnt", done_cnt - b_done, 1);
        check("t1_beats", beat_cnt - b_beat, 4);
        check("t1_consec", last_hs_cyc - t_first, 3);
        check("t1_done_lat", done_cyc - last_hs_cyc, 1);

        // Backpressure
        b_done = done_cnt;
        b_beat = beat_cnt;
        do_start();
        foreach (pat[i]) begin
            m_axis_tready = pat[i];
            tick();
        end
        m_axis_tready = 1'b1;
        wait_done("t2_done");
        tick();
        check("t2_beats", beat_cnt - b_beat, 4);
        check("t2_done_cnt", done_cnt - b_done, 1);

        // Write racing start, write while busy, post-frame write
        wr_en   = 1'b1;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = 8'd9;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("t3_race_first", m_axis_tdata, 1);
        wr(1, 1, 7, 0);
        wait_done("t3_done_a");
        tick();
        wr(0, 0, 9, 1);
        do_start();
        check("t3_post_first", m_axis_tdata, 9);
        wait_done("t3_done_b");
        tick();

        // Start while busy
        b_done = done_cnt;
        b_beat = beat_cnt;
        do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4_done");
        repeat (5) tick();
        check("t4_beats", beat_cnt - b_beat, 4);
        check("t4_done_cnt", done_cnt - b_done, 1);
        check("t4_sb_empty", sbq.size(), 0);

        // Reset mid-frame after beat 2 accepted
        b_done = done_cnt;
        do_start();
        tick();
        tick();
        areset        = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        check("t5_tvalid", m_axis_tvalid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        areset = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) model[r][c] = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("t5_no_done", done_cnt - b_done, 0);
        do_start();
        check("t5_cleared", m_axis_tdata, 0);
        wait_done("t5_done_b");
        tick();

        // Back-to-back frames
        load_1234();
        b_done  = done_cnt;
        b_beat  = beat_cnt;
        b_tuser = tuser_cnt;
        do_start();
        wait_done("t6_done_a");
        do_start();
        check("t6_b2b_valid", m_axis_tvalid, 1);
        check("t6_b2b_first", m_axis_tdata, 1);
        wait_done("t6_done_b");
        tick();
        check("t6_beats", beat_cnt - b_beat, 8);
        check("t6_tuser", tuser_cnt - b_tuser, 2);
        check("t6_done_cnt", done_cnt - b_done, 2);
        check("sb_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
